// File: rtl/hpdcache_sram_wbyteenable_ctrl.sv
// Initiator-side controller for a single-port byte-enable-write SRAM: optional
// zero-fill sweep after reset, valid/ready request port, 2-entry read response FIFO.
module hpdcache_sram_wbyteenable_ctrl #(
  parameter int unsigned ADDR_SIZE   = 6,
  parameter int unsigned DATA_SIZE   = 64,
  parameter int unsigned DEPTH       = 2**ADDR_SIZE,
  parameter int unsigned INIT_ENABLE = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,

  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [ADDR_SIZE-1:0]     req_addr,
  input  logic [DATA_SIZE-1:0]     req_wdata,
  input  logic [DATA_SIZE/8-1:0]   req_be,

  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_SIZE-1:0]     rsp_rdata,

  output logic                     init_done,

  output logic                     sram_cs,
  output logic                     sram_we,
  output logic [ADDR_SIZE-1:0]     sram_addr,
  output logic [DATA_SIZE-1:0]     sram_wdata,
  output logic [DATA_SIZE/8-1:0]   sram_wbyteenable,
  input  logic [DATA_SIZE-1:0]     sram_rdata
);

  localparam int unsigned BE_SIZE = DATA_SIZE / 8;

  localparam logic [1:0] ST_RST  = 2'd0;
  localparam logic [1:0] ST_INIT = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  localparam logic [ADDR_SIZE-1:0] INIT_LAST = ADDR_SIZE'(DEPTH - 1);

  logic [1:0]           state_reg, state_next;
  logic [ADDR_SIZE-1:0] init_cnt_reg, init_cnt_next;
  logic                 rd_pend_reg;
  logic [DATA_SIZE-1:0] fifo_reg [2];
  logic                 wr_ptr_reg, rd_ptr_reg;
  logic [1:0]           rsp_cnt_reg;

  logic                 init_wr;
  logic                 req_fire, rd_fire, wr_fire;
  logic                 push, pop;
  logic [2:0]           occ_after;

  // ---------------------------------------------------------------------------
  // Control FSM and sweep counter
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    init_cnt_next = init_cnt_reg;
    case (state_reg)
      ST_RST: begin
        init_cnt_next = '0;
        state_next    = (INIT_ENABLE != 0) ? ST_INIT : ST_RUN;
      end
      ST_INIT: begin
        if (init_cnt_reg == INIT_LAST) begin
          state_next = ST_RUN;
        end else begin
          init_cnt_next = init_cnt_reg + 1'b1;
        end
      end
      ST_RUN: begin
        state_next = ST_RUN;
      end
      default: begin
        state_next = ST_RST;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_RST;
      init_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      init_cnt_reg <= init_cnt_next;
    end
  end

  assign init_done = (state_reg == ST_RUN);
  assign init_wr   = (state_reg == ST_INIT);

  // ---------------------------------------------------------------------------
  // Request handshake: a read in flight or a buffered response both hold a slot,
  // and a pop this cycle frees one immediately (rsp_ready -> req_ready path).
  // ---------------------------------------------------------------------------
  assign rsp_valid = (rsp_cnt_reg != 2'd0);
  assign pop       = rsp_valid && rsp_ready;
  assign push      = rd_pend_reg;
  assign occ_after = 3'(rsp_cnt_reg) + 3'(rd_pend_reg) - 3'(pop);
  assign req_ready = init_done && (occ_after < 3'd2);

  assign req_fire  = req_valid && req_ready;
  assign rd_fire   = req_fire && !req_we;
  assign wr_fire   = req_fire && req_we;

  // ---------------------------------------------------------------------------
  // SRAM port: sweep writes take priority (requests are blocked during INIT)
  // ---------------------------------------------------------------------------
  assign sram_cs   = init_wr || req_fire;
  assign sram_we   = init_wr || wr_fire;
  assign sram_addr = init_wr  ? init_cnt_reg :
                     req_fire ? req_addr     : '0;

  genvar gi;
  generate
    for (gi = 0; gi < BE_SIZE; gi++) begin : g_lane
      assign sram_wbyteenable[gi]  = init_wr | (wr_fire & req_be[gi]);
      assign sram_wdata[gi*8 +: 8] = wr_fire ? req_wdata[gi*8 +: 8] : 8'h00;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Read pipeline and response FIFO
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend_reg <= 1'b0;
      wr_ptr_reg  <= 1'b0;
      rd_ptr_reg  <= 1'b0;
      rsp_cnt_reg <= 2'd0;
    end else begin
      rd_pend_reg <= rd_fire;
      if (push) begin
        wr_ptr_reg <= ~wr_ptr_reg;
      end
      if (pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      rsp_cnt_reg <= rsp_cnt_reg + 2'(push) - 2'(pop);
    end
  end

  generate
    for (gi = 0; gi < 2; gi++) begin : g_fifo
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          fifo_reg[gi] <= '0;
        end else if (push && (wr_ptr_reg == 1'(gi))) begin
          fifo_reg[gi] <= sram_rdata;
        end
      end
    end
  endgenerate

  assign rsp_rdata = fifo_reg[rd_ptr_reg];

  // The ready rule must guarantee a free slot for every returning read.
  fifo_no_overflow: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(push && !pop && (rsp_cnt_reg == 2'd2))
  );

endmodule

// File: tb/tb_hpdcache_sram_wbyteenable_ctrl.sv
// Bench for hpdcache_sram_wbyteenable_ctrl: SRAM model, reference memory,
// scoreboard of expected read data, directed and random stimulus.
module tb_hpdcache_sram_wbyteenable_ctrl;

  localparam int AW    = 6;
  localparam int DW    = 64;
  localparam int BW    = DW / 8;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [BW-1:0] req_be;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          init_done;
  logic          sram_cs, sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [BW-1:0] sram_wbyteenable;
  logic [DW-1:0] sram_rdata;

  always #5 clk = ~clk;

  hpdcache_sram_wbyteenable_ctrl #(
    .ADDR_SIZE(AW), .DATA_SIZE(DW), .DEPTH(DEPTH), .INIT_ENABLE(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .init_done(init_done),
    .sram_cs(sram_cs), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_wbyteenable(sram_wbyteenable),
    .sram_rdata(sram_rdata)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // SRAM macro model: byte-enable write, registered read, garbage power-up
  logic [DW-1:0] sram_mem [DEPTH];
  bit            seeded = 1'b0;
  always @(posedge clk) begin
    if (!seeded) begin
      for (int i = 0; i < DEPTH; i++) sram_mem[i] <= {$urandom, $urandom};
      sram_rdata <= {$urandom, $urandom};
      seeded <= 1'b1;
    end else if (sram_cs) begin
      if (sram_we) begin
        for (int b = 0; b < BW; b++)
          if (sram_wbyteenable[b]) sram_mem[sram_addr][b*8 +: 8] <= sram_wdata[b*8 +: 8];
      end else begin
        sram_rdata <= sram_mem[sram_addr];
      end
    end
  end

  // Reference model and scoreboard
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] exp_q [$];
  int            pop_cyc_q [$];
  int            n_rd  = 0;
  int            n_rsp = 0;
  bit            in_run = 1'b0;
  logic          pop_now;
  logic [DW-1:0] exp_data;

  always @(negedge clk) begin
    if (!rst_n) begin
      // after any reset the sweep is expected to leave the array zeroed
      exp_q.delete();
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    end else begin
      pop_now = rsp_valid && rsp_ready;
      if (!sram_cs) begin
        chk("idle_ctl", {sram_we, sram_addr, sram_wbyteenable}, 64'd0);
        chk("idle_wdata", sram_wdata, 64'd0);
      end
      if (in_run)
        chk("req_ready", req_ready, 64'((exp_q.size() - int'(pop_now)) < 2));
      if (pop_now) begin
        n_rsp++;
        pop_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", rsp_valid, 64'd0);
        end else begin
          exp_data = exp_q.pop_front();
          $display("rsp %0d: data=%h expected=%h", n_rsp, rsp_rdata, exp_data);
          chk("rsp_data", rsp_rdata, exp_data);
        end
      end
      if (req_valid && req_ready) begin
        if (req_we) begin
          for (int b = 0; b < BW; b++)
            if (req_be[b]) ref_mem[req_addr][b*8 +: 8] = req_wdata[b*8 +: 8];
        end else begin
          n_rd++;
          exp_q.push_back(ref_mem[req_addr]);
        end
      end
    end
  end

  task automatic chk_reset_outputs();
    chk("rst_ctl", {req_ready, rsp_valid, init_done, sram_cs, sram_we}, 64'd0);
    chk("rst_addr", sram_addr, 64'd0);
    chk("rst_be", sram_wbyteenable, 64'd0);
    chk("rst_wdata", sram_wdata, 64'd0);
    chk("rst_rdata", rsp_rdata, 64'd0);
  endtask

  // Called right after reset release; cycle 1 is the first cycle after release.
  task automatic check_sweep(input int abort_at);
    int writes, bad, first_k, done_k;
    writes = 0; bad = 0; first_k = -1; done_k = -1;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      if (init_done) begin
        done_k = k;
        break;
      end
      if (req_ready) bad++;
      if (sram_cs) begin
        if (first_k < 0) first_k = k;
        if (sram_we && int'(sram_addr) == writes && sram_wdata == '0 && sram_wbyteenable == '1)
          writes++;
        else
          bad++;
        if (abort_at >= 0 && int'(sram_addr) == abort_at) begin
          rst_n = 1'b0;
          #1;
          chk_reset_outputs();
          return;
        end
      end
    end
    chk("sweep_first_cycle", 64'(first_k), 64'd2);
    chk("sweep_writes", 64'(writes), 64'd64);
    chk("sweep_bad_cycles", 64'(bad), 64'd0);
    chk("init_done_cycle", 64'(done_k), 64'd66);
    chk("ready_after_init", req_ready, 64'd1);
    in_run = 1'b1;
  endtask

  task automatic send(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [BW-1:0] be);
    bit acc;
    acc = 1'b0;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_be = be;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) acc = 1'b1;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    req_valid = 1'b0;
    chk("send_accepted", 64'(acc), 64'd1);
  endtask

  // Read with rsp_ready=1 and an empty FIFO: data must appear exactly two cycles later
  task automatic read_check(input logic [AW-1:0] a, input logic [DW-1:0] exp);
    send(1'b0, a, '0, '0);
    @(negedge clk);
    chk("lat_t_plus_1_valid", rsp_valid, 64'd0);
    @(negedge clk);
    chk("lat_t_plus_2_valid", rsp_valid, 64'd1);
    chk("lat_t_plus_2_data", rsp_rdata, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !rsp_valid) break;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc, base;
    rst_n = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_be = '0; rsp_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check_sweep(-1);
    @(posedge clk); #1;

    read_check(6'd17, 64'd0);
    send(1'b1, 6'd5, 64'h1122334455667788, 8'hFF);
    read_check(6'd5, 64'h1122334455667788);
    send(1'b1, 6'd5, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
    read_check(6'd5, 64'h11223344AAAAAAAA);

    // Backpressure: distinct contents at 40..43, then 4 reads with rsp_ready low
    for (int i = 0; i < 4; i++) send(1'b1, AW'(40 + i), {$urandom, $urandom}, 8'hFF);
    rsp_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      req_valid = 1'b1; req_we = 1'b0; req_addr = AW'(40 + acc);
      @(negedge clk);
      if (req_ready) acc++;
      @(posedge clk); #1;
    end
    chk("bp_accepted", 64'(acc), 64'd2);
    @(negedge clk);
    chk("bp_ready_low", req_ready, 64'd0);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 40 && acc < 4; i++) begin
      req_valid = 1'b1; req_we = 1'b0; req_addr = AW'(40 + acc);
      @(negedge clk);
      if (req_ready) acc++;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    chk("bp_all_accepted", 64'(acc), 64'd4);
    drain();

    // Back-to-back reads of 0..15
    base = pop_cyc_q.size();
    for (int i = 0; i < 16; i++) begin
      req_valid = 1'b1; req_we = 1'b0; req_addr = AW'(i);
      @(negedge clk);
      chk("b2b_ready", req_ready, 64'd1);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    drain();
    chk("b2b_rsp_count", 64'(pop_cyc_q.size() - base), 64'd16);
    if (pop_cyc_q.size() >= base + 16)
      chk("b2b_rsp_span", 64'(pop_cyc_q[base + 15] - pop_cyc_q[base]), 64'd15);

    // Random mixed traffic with random response backpressure
    for (int i = 0; i < 600; i++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_we    = 1'($urandom_range(0, 1));
      req_addr  = AW'($urandom_range(0, DEPTH - 1));
      req_wdata = {$urandom, $urandom};
      req_be    = BW'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    drain();
    chk("rsp_total", 64'(n_rsp), 64'(n_rd));

    // Reset in the middle of the sweep, then a full sweep from address 0
    in_run = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check_sweep(30);
    chk("abort_reset_low", rst_n, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check_sweep(-1);
    @(posedge clk); #1;
    read_check(6'd5, 64'd0);
    read_check(6'd17, 64'd0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
